// File: rtl/parity_pkg.sv
// ============================================================================
// Module      : parity_pkg
// Description : Shared helpers for the streaming parity checker: the parity
//               error function, packet width and counter saturation limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_pkg;

    // A packet is DATA_W payload bits plus one parity bit at index DATA_W,
    // so PKT_W = DATA_W + 1.
    localparam int c_max_pkt_w = 1024;

    function automatic int pkt_w(input int data_w);
        return data_w + 1;
    endfunction

    // The word arrives zero-extended to c_max_pkt_w; zero padding leaves
    // the XOR reduction unchanged.
    function automatic logic parity_err(input logic [c_max_pkt_w-1:0] word,
                                        input logic                   odd);
        return (^word) ^ odd;
    endfunction

    function automatic logic [31:0] cnt_max(input int cnt_w);
        if (cnt_w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/parity_err_counter.sv
// ============================================================================
// Module      : parity_err_counter
// Description : Sticky error flag plus saturating error counter; an error in
//               the same cycle as a clear takes priority over the clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_err_counter
    import parity_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic             sticky,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(cnt_max(CNT_W));

    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (inc) begin
            r_sticky <= 1'b1;
            if (clr) begin
                r_count <= CNT_W'(1);
            end else if (r_count != c_cnt_max) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (clr) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end
    end

    assign sticky = r_sticky;
    assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/parity_stream_checker.sv
// ============================================================================
// Module      : parity_stream_checker
// Description : Valid/ready parity checker with a single-entry output
//               register and error status. Optional macro PARITY_DROP_EN
//               drops words with bad parity instead of forwarding them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_error,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);

    localparam int c_pkt_w = pkt_w(DATA_W);

    logic [c_max_pkt_w-1:0] w_word_ext;
    logic                   w_err;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_drain;

    logic                   r_valid;
    logic [DATA_W-1:0]      r_data;
    logic                   r_error;

    assign w_word_ext = c_max_pkt_w'(in_data[c_pkt_w-1:0]);
    assign w_err      = parity_err(w_word_ext, (ODD_PARITY != 0));

    // Ready while empty or while the held word leaves this cycle.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_valid && out_ready;

`ifdef PARITY_DROP_EN
    assign w_load = w_accept && !w_err;
`else
    assign w_load = w_accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_error <= 1'b0;
        end else if (w_load) begin
            r_data  <= in_data[DATA_W-1:0];
`ifdef PARITY_DROP_EN
            r_error <= 1'b0;
`else
            r_error <= w_err;
`endif
        end
    end

    parity_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (err_clr),
        .inc    (w_accept && w_err),
        .sticky (err_sticky),
        .count  (err_count)
    );

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_error = r_error;

endmodule

`default_nettype wire

// File: doc/parity_stream_checker.md
Name: parity_stream_checker

Overview:
Parametrised streaming parity checker: next generation of the 9-bit combinational parity error checker. Accepts words of DATA_W payload bits plus one parity bit (MSB) on a valid/ready stream. Registers each word with its error flag, optionally drops bad words, and keeps a sticky error flag and a saturating error counter for status. Sits between a serial/link receiver and downstream consumers.

Parameters:
DATA_W, 8, payload width; input word is DATA_W+1 bits, parity bit at index DATA_W.
ODD_PARITY, 0, 0 = even parity (XOR of all DATA_W+1 bits must be 0); 1 = odd parity (XOR must be 1).
CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  DATA_W+1  payload [DATA_W-1:0] plus parity bit [DATA_W]
in_valid  input  1  in_data valid
in_ready  output  1  checker can accept a word this cycle
out_data  output  DATA_W  registered payload, parity bit stripped
out_error  output  1  parity error flag for out_data
out_valid  output  1  out_data/out_error valid
out_ready  input  1  downstream accepts
err_clr  input  1  one-cycle pulse: clear err_sticky and err_count
err_sticky  output  1  set on any detected error since reset/clear
err_count  output  CNT_W  number of detected errors, saturates at all-ones

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_error=0, err_sticky=0, err_count=0. Reset mid-transfer discards the held word; no handshake completes in a reset cycle.
- Error detect (combinational): err = ^in_data ^ ODD_PARITY.
- Single-entry output register: in_ready = !out_valid || out_ready (combinational, no input-to-output bubble).
- Accept: in_valid && in_ready. On accept, out_data <= in_data[DATA_W-1:0], out_error <= err, out_valid <= 1. Latency: exactly 1 cycle from accept to out_valid.
- Output handshake: out_valid && out_ready completes a transfer; if no new accept in the same cycle, out_valid <= 0. Accept and drain in the same cycle: register reloads, out_valid stays 1 (full throughput, one word per cycle).
- While out_valid && !out_ready: out_data, out_error, out_valid held stable; in_ready=0.
- Status counts every accepted word with err=1 (dropped or not). err_count increments by 1, holds at 2^CNT_W-1.
- err_clr alone: err_sticky<=0, err_count<=0 next cycle.
- err_clr and erroneous accept in the same cycle: error wins; err_sticky<=1, err_count<=1.
- in_valid without in_ready: no state change; source must hold in_data stable.

Optional Feature:
Macro PARITY_DROP_EN. Defined: an accepted word with err=1 is not loaded into the output register (out_valid unaffected by that accept, except that a same-cycle drain still clears it); status still updated; out_error is then always 0. Not defined: every accepted word is forwarded with its out_error flag.

Decomposition:
- Package parity_pkg: function parity_err(word, odd) returning the error bit; localparam PKT_W = DATA_W+1 convention documented there; CNT saturation max as a constant function of CNT_W.
- One sub-module natural: parity_err_counter (sticky flag + saturating counter with clear/increment priority). Parity reduction stays inline via the package function.

Test Plan:
- Reset then DATA_W=8, even: send 9'b0_00110101 (four ones, parity 0) -> next cycle out_valid=1, out_data=8'h35, out_error=0, err_count=0.
- Send 9'b0_00110100 (three ones) -> out_error=1, err_sticky=1, err_count=1; with PARITY_DROP_EN, out_valid stays 0 and err_count=1.
- ODD_PARITY=1: send 9'b1_00110101 -> out_error=0; 9'b1_00110100 -> out_error=1.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, output stable; release -> one word per cycle, no loss or duplication over 16 back-to-back words.
- CNT_W=2: 5 bad words -> err_count sticks at 3; err_clr in the same cycle as a 6th bad word -> err_count=1, err_sticky=1; err_clr alone -> 0/0.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, err_count=0, in_ready=1.
